// File: rtl/ts_packet_arbiter.sv
// ts_packet_arbiter: packet-granular round-robin merge of four MPEG2-TS
// FIFO streams into one byte stream. A grant lasts one whole 188-byte
// packet; bytes before a sync byte are discarded, and a channel that runs
// dry mid-packet is released after TIMEOUT empty cycles.
module ts_packet_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PKT_LEN    = 188,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'h47,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [DATA_WIDTH-1:0] ch_data0,
  input  logic [DATA_WIDTH-1:0] ch_data1,
  input  logic [DATA_WIDTH-1:0] ch_data2,
  input  logic [DATA_WIDTH-1:0] ch_data3,
  input  logic [3:0]            ch_empty,
  output logic [3:0]            ch_rd,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [1:0]            out_ch,
  output logic                  out_abort,
  output logic                  sync_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_XFER} state_e;

  state_e                        state_q, state_d;
  logic [1:0]                    gnt_q, gnt_d;
  logic [1:0]                    last_q, last_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_sop_q, out_sop_d;
  logic                          out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic [1:0]                    out_ch_q, out_ch_d;
  logic                          out_abort_q, out_abort_d;
  logic                          sync_err_q, sync_err_d;

  logic [3:0][DATA_WIDTH-1:0]    ch_data_a;
  logic [DATA_WIDTH-1:0]         head;
  logic                          can_pop;
  logic                          pop;
  logic                          gnt_empty;
  logic [TW-1:0]                 tmo_inc;
  logic                          tmo_hit;

  assign ch_data_a = {ch_data3, ch_data2, ch_data1, ch_data0};
  assign head      = ch_data_a[gnt_q];
  assign gnt_empty = ch_empty[gnt_q];
  // A byte may be popped only when the output register is free or draining.
  assign can_pop   = !out_valid_q || out_ready;
  assign pop       = (state_q != S_IDLE) && !gnt_empty && can_pop;
  assign tmo_inc   = tmo_q + TW'(1);
  assign tmo_hit   = (tmo_inc == TW'(TIMEOUT));

  // Only the granted channel's strobe can be high.
  for (genvar i = 0; i < 4; i++) begin : g_rd
    assign ch_rd[i] = pop && (gnt_q == 2'(i));
  end

  // Next-state: grant scan, sync hunt, packet transfer, stall timeout.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found       = 1'b0;
    idx         = '0;
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_abort_d = 1'b0;
    sync_err_d  = 1'b0;

    // Handshake with nothing new behind it empties the output register.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        // Scan starts just past the last served channel; it comes last.
        for (int i = 1; i <= 4; i++) begin
          idx = last_q + 2'(i);
          if (!found && !ch_empty[idx]) begin
            found = 1'b1;
            gnt_d = idx;
          end
        end
        if (found) begin
          tmo_d   = '0;
          state_d = S_HUNT;
        end
      end
      S_HUNT: begin
        if (pop) begin
          tmo_d = '0;
          if (head == SYNC_BYTE) begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b1;
            out_eop_d   = 1'b0;
            out_data_d  = head;
            out_ch_d    = gnt_q;
            cnt_d       = 8'd1;
            state_d     = S_XFER;
          end else begin
            sync_err_d = 1'b1;
          end
        end else if (gnt_empty) begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            last_d  = gnt_q;
            state_d = S_IDLE;
          end
        end
      end
      S_XFER: begin
        if (pop) begin
          tmo_d       = '0;
          out_valid_d = 1'b1;
          out_sop_d   = 1'b0;
          out_data_d  = head;
          out_ch_d    = gnt_q;
          cnt_d       = cnt_q + 8'd1;
          out_eop_d   = (cnt_q == 8'(PKT_LEN - 1));
          if (cnt_q == 8'(PKT_LEN - 1)) begin
            cnt_d   = '0;
            last_d  = gnt_q;
            state_d = S_IDLE;
          end
        end else if (gnt_empty) begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            out_abort_d = 1'b1;
            cnt_d       = '0;
            last_d      = gnt_q;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; last resets to 3 so the first scan hits ch0.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'd0;
      last_q      <= 2'd3;
      cnt_q       <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= 2'd0;
      out_abort_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_abort_q <= out_abort_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_abort = out_abort_q;
  assign sync_err  = sync_err_q;

endmodule

// File: doc/ts_packet_arbiter.md
# ts_packet_arbiter

Packet-granular round-robin arbiter in the 100 MHz read domain. It drains the four input FIFOs and merges their MPEG2-TS streams into one byte stream. Only whole 188-byte packets aligned on the 0x47 sync byte are forwarded. A channel keeps its grant for a full packet, so packets from different channels never interleave. A channel that stalls mid-packet is dropped after a timeout so it cannot starve the others.

## Interface
- DATA_WIDTH, 8, byte width; the block is only defined for 8
- PKT_LEN, 188, bytes per TS packet
- SYNC_BYTE, 8'h47, TS sync byte
- TIMEOUT, 1024, consecutive empty cycles tolerated on the granted channel before release
- rclk  in  1  read-domain clock (100 MHz); the block's only clock
- rrst_n  in  1  asynchronous active-low reset
- ch_data0..ch_data3  in  DATA_WIDTH  FIFO head bytes; first-word-fall-through, valid whenever the matching ch_empty is low
- ch_empty  in  4  per-channel FIFO empty flags
- ch_rd  out  4  per-channel pop strobes; at most one bit high per cycle
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  DATA_WIDTH  merged byte
- out_valid  out  1  out_data valid
- out_sop  out  1  with out_valid: first byte of a packet (the sync byte)
- out_eop  out  1  with out_valid: byte PKT_LEN-1 of a packet
- out_ch  out  2  source channel of the current byte
- out_abort  out  1  one-cycle pulse: the packet in progress was truncated
- sync_err  out  1  one-cycle pulse: one non-sync byte was discarded while hunting

## Operation
- **States.** IDLE, HUNT, XFER. Registers:
  - gnt[1:0]: granted channel.
  - last[1:0]: last channel served.
  - cnt: byte index within the packet, 8 bits.
  - tmo: empty-cycle counter, clog2(TIMEOUT+1) bits.
- **Pop rule.** can_pop = !out_valid | out_ready. ch_rd[gnt] = (state is HUNT or XFER) & !ch_empty[gnt] & can_pop. All other ch_rd bits are 0.
- **IDLE.**
  - Scan channels last+1, last+2, last+3, last, all modulo 4. The first one with ch_empty low wins.
  - Load gnt with the winner, clear tmo, go to HUNT.
  - If all channels are empty, stay in IDLE.
- **HUNT.**
  - On a pop where the byte equals SYNC_BYTE: register it as out_data with out_sop=1, set cnt=1, go to XFER.
  - On a pop where the byte differs: discard it without asserting out_valid, pulse sync_err, stay in HUNT.
- **XFER.**
  - Each pop registers the byte as output and increments cnt.
  - The pop at cnt==PKT_LEN-1 sets out_eop, sets last=gnt, goes to IDLE.
- **Timeout (HUNT and XFER).**
  - tmo increments on every cycle with ch_empty[gnt]=1. It clears on every pop.
  - Cycles where out_ready is low and the channel is not empty do not count.
  - When tmo reaches TIMEOUT: set last=gnt and go to IDLE. From XFER also pulse out_abort for one cycle. From HUNT, go to IDLE silently.
- **Output register.** It loads on a forwarded pop. It clears out_valid on an out_ready handshake with no new load. out_ch is loaded with gnt together with out_data.
- **Simultaneous events.** A handshake and a pop in the same cycle are legal, giving 1 byte per cycle throughput. An EOP pop and an IDLE grant never share a cycle: IDLE always costs 1 cycle.
- **Reset.**
  - Outputs: out_valid, out_sop, out_eop, out_abort, sync_err, ch_rd all 0; out_data 0; out_ch 0.
  - Internal: state IDLE, last=3 so the first scan starts at ch0, gnt=0, cnt=0, tmo=0.
  - Reset mid-packet truncates the packet with no out_abort pulse.

## Timing
- Registered outputs except ch_rd, which is combinational from state, gnt, ch_empty, out_valid and out_ready.
- Latency: a grant in IDLE at cycle t gives the first pop at t+1 and the first out_valid at t+2. Each subsequent byte is registered the cycle after its pop.
- A full packet with no stalls occupies 188 consecutive out_valid cycles. The next packet's first byte appears 2 cycles after eop.
- out_abort is asserted in the cycle after tmo reaches TIMEOUT. The granted channel's ch_rd is already low in that cycle.
- out_sop, out_eop and out_ch are meaningful only while out_valid is high. They hold their value while out_valid is high and out_ready is low.

## Test plan
- **Single channel.** ch1 holds two 188-byte packets starting 0x47, out_ready=1 → 376 output bytes with out_ch=1. sop at bytes 0 and 188, eop at bytes 187 and 375. One non-valid gap between the packets.
- **Round robin.** All four channels hold full packets → grant order ch0, ch1, ch2, ch3, ch0. No interleaving within a packet.
- **Hunt.** ch2 holds 0x00, 0x12, 0x47 followed by 187 bytes → two sync_err pulses. The first output byte is 0x47 with out_sop=1, followed by a full packet.
- **Timeout.** ch0 goes empty after 100 bytes, TIMEOUT=16 → out_abort pulses 17 cycles after the last pop and no out_eop is asserted. A pending packet on ch1 is then granted.
- **Backpressure.** out_ready toggles every other cycle → the full packet arrives intact with 0 sync_err. ch_rd never pops while out_valid=1 and out_ready=0. tmo does not advance.
- **Mid-packet reset.** rrst_n asserted at byte 50 → all outputs are 0 asynchronously. After release, the first grant goes to ch0.
